ps2_cmd_ctrl: RTL and testbench

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_cmd_ctrl_if.sv | 20 ++
 rtl/ps2_tx_shifter.sv | 49 ++++
 rtl/ps2_cmd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 host command controller.
package ps2_pkg;

    localparam logic [7:0] ED = 8'hED;
    localparam logic [7:0] FA = 8'hFA;
    localparam logic [7:0] FE = 8'hFE;
    localparam logic [7:0] FF = 8'hFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_LACK    = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;
    localparam logic [2:0] S_FAIL    = 3'd7;

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_cmd_ctrl_if.sv
// Host command handshake and receiver byte feed for the PS/2 command controller.
interface ps2_cmd_ctrl_if;

    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rx_byte;
    logic       rx_strobe;

    modport master (
        output cmd_byte, cmd_valid, rx_byte, rx_strobe,
        input  cmd_ready
    );

    modport slave (
        input  cmd_byte, cmd_valid, rx_byte, rx_strobe,
        output cmd_ready
    );

endinterface

// File: rtl/ps2_tx_shifter.sv
// Host-to-device serialiser: one bit per device falling edge, data then odd parity,
// released on the 10th edge.
module ps2_tx_shifter
    import ps2_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_en,
    input  logic       i_fall,
    input  logic [7:0] i_byte,
    output logic       o_data_oe,
    output logic       o_done
);

    logic [8:0] r_shift;
    logic [3:0] r_cnt;
    logic       r_oe;
    logic       w_step;

    assign w_step    = i_en & i_fall;
    assign o_done    = w_step & (r_cnt == 4'd9);
    assign o_data_oe = r_oe;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
        end else if (i_load) begin
            // start bit is the low level held until the first edge
            r_shift <= {odd_par(i_byte), i_byte};
            r_cnt   <= '0;
            r_oe    <= 1'b1;
        end else if (!i_en) begin
            r_oe <= 1'b0;
        end else if (w_step) begin
            if (r_cnt == 4'd9) begin
                r_oe  <= 1'b0;
                r_cnt <= 4'd10;
            end else begin
                r_oe    <= ~r_shift[0];
                r_shift <= {1'b0, r_shift[8:1]};
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command sequencer: inhibit, request-to-send, line ack, device
// response, retries and timeouts, plus automatic LED updates.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_TRIES      = 3
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_data,
    output logic           o_ps2_clk_oe,
    output logic           o_ps2_data_oe,
    input  logic [2:0]     i_leds,
    ps2_cmd_ctrl_if.slave  bus,
    output logic           o_rx_owned,
    output logic           o_busy,
    output logic           o_error
);

    logic        r_clk_s1, r_clk_s2, r_clk_d;
    logic        r_dat_s1, r_dat_s2;
    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic [7:0]  r_tries;
    logic [7:0]  r_byte;
    logic [2:0]  r_mask;
    logic [2:0]  r_last_leds;
    logic        r_is_led;
    logic        r_phase;
    logic        r_ack;
    logic        r_error;

    logic w_fall, w_done, w_sh_oe, w_load, w_inh_done;
    logic w_in_tmo, w_tmo, w_bad, w_good, w_tx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall     = r_clk_d & ~r_clk_s2;
    assign w_inh_done = (r_cnt == 32'(INHIBIT_CYCLES - 1));
    assign w_load     = (r_state == S_INHIBIT) & w_inh_done;
    assign w_tx       = (r_state == S_REQ) | (r_state == S_SEND);
    assign w_in_tmo   = (r_state >= S_REQ) & (r_state <= S_RESP);
    assign w_tmo      = w_in_tmo & (r_cnt == 32'(TIMEOUT_CYCLES - 1));

    assign w_bad  = w_tmo
                  | ((r_state == S_LACK) & ~r_ack)
                  | ((r_state == S_RESP) & bus.rx_strobe & (bus.rx_byte != FA));
    assign w_good = ~w_tmo & (r_state == S_RESP) & bus.rx_strobe
                  & (bus.rx_byte == FA);

    ps2_tx_shifter u_tx (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_en      (w_tx),
        .i_fall    (w_fall),
        .i_byte    (r_byte),
        .o_data_oe (w_sh_oe),
        .o_done    (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tries     <= '0;
            r_byte      <= '0;
            r_mask      <= '0;
            r_last_leds <= '0;
            r_is_led    <= 1'b0;
            r_phase     <= 1'b0;
            r_ack       <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_in_tmo) r_cnt <= r_cnt + 32'd1;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_byte   <= bus.cmd_byte;
                        r_is_led <= 1'b0;
                        r_phase  <= 1'b0;
                        r_tries  <= 8'd1;
                        r_error  <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_INHIBIT;
                    end else if (i_leds != r_last_leds) begin
                        r_mask   <= i_leds;
                        r_byte   <= ED;
                        r_is_led <= 1'b1;
                        r_phase  <= 1'b0;
                        r_tries  <= 8'd1;
                        r_error  <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (w_inh_done) begin
                        r_cnt   <= '0;
                        r_state <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_REQ:  if (w_fall) r_state <= S_SEND;
                S_SEND: if (w_done) r_state <= S_STOP;
                S_STOP: begin
                    if (w_fall) begin
                        r_ack   <= ~r_dat_s2;
                        r_state <= S_LACK;
                    end
                end
                S_LACK: if (r_ack) r_state <= S_RESP;
                S_RESP: ;
                S_FAIL: begin
                    // adopting the mask stops a dead device from looping forever
                    r_error <= 1'b1;
                    if (r_is_led) r_last_leds <= r_mask;
                    r_state <= S_IDLE;
                end
            endcase
            if (w_bad) begin
                if (r_tries < 8'(MAX_TRIES)) begin
                    r_tries <= r_tries + 8'd1;
                    r_cnt   <= '0;
                    r_state <= S_INHIBIT;
                end else begin
                    r_state <= S_FAIL;
                end
            end else if (w_good) begin
                if (r_is_led && !r_phase) begin
                    r_phase <= 1'b1;
                    r_byte  <= {5'b0, r_mask};
                    r_tries <= 8'd1;
                    r_cnt   <= '0;
                    r_state <= S_INHIBIT;
                end else begin
                    if (r_is_led) r_last_leds <= r_mask;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign o_ps2_clk_oe  = (r_state == S_INHIBIT);
    assign o_ps2_data_oe = w_sh_oe & w_tx;
    assign o_busy        = (r_state != S_IDLE);
    assign o_rx_owned    = (r_state != S_IDLE);
    assign o_error       = r_error;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl with a simple open-drain PS/2 device model.
module tb_ps2_cmd_ctrl;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TMO = 1000;
    localparam int H   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_oe, data_oe;
    logic busy, rx_owned, error;
    logic [2:0] leds = 3'b000;
    wire ps2_clk_line  = ~(clk_oe | dev_clk_low);
    wire ps2_data_line = ~(data_oe | dev_data_low);

    ps2_cmd_ctrl_if bus();

    ps2_cmd_ctrl #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .MAX_TRIES      (3)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ps2_clk     (ps2_clk_line),
        .i_ps2_data    (ps2_data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe),
        .i_leds        (leds),
        .bus           (bus),
        .o_rx_owned    (rx_owned),
        .o_busy        (busy),
        .o_error       (error)
    );

    int checks = 0;
    int failures = 0;

    int inh_run = 0, inh_last = 0;
    int req_run = 0, req_last = 0;
    always @(posedge clk) begin
        if (clk_oe) inh_run <= inh_run + 1;
        else if (inh_run != 0) begin
            inh_last <= inh_run;
            inh_run  <= 0;
        end
        if (data_oe) req_run <= req_run + 1;
        else if (req_run != 0) begin
            req_last <= req_run;
            req_run  <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string tag);
        int w = 0;
        while (!(data_oe && !clk_oe) && w < 3000) begin
            tick(1);
            w++;
        end
        chk({tag, "_req"}, {31'b0, data_oe & ~clk_oe}, 1);
        tick(1);
        chk({tag, "_inh_len"}, inh_last, INH);
    endtask

    task automatic dev_xfer(input string tag, input logic [7:0] exp_b,
                            input bit ack, input logic [7:0] resp,
                            input int stop_at);
        logic [10:0] bits = '0;
        logic [7:0]  b;
        tick(5);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                tick(2);
            end
            dev_clk_low = 1'b1;
            tick(H);
            if (k == stop_at) begin
                dev_clk_low = 1'b0;
                return;
            end
            bits[k-1] = ps2_data_line;
            dev_clk_low = 1'b0;
            tick(H);
        end
        dev_data_low = 1'b0;
        b = bits[7:0];
        chk({tag, "_byte"}, b, exp_b);
        chk({tag, "_par"}, bits[8], ~^exp_b);
        chk({tag, "_stop"}, bits[9], 1);
        if (ack) begin
            tick(3);
            bus.rx_byte   = resp;
            bus.rx_strobe = 1'b1;
            tick(1);
            bus.rx_strobe = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        while (busy && w < 5000) begin
            tick(1);
            w++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bus.cmd_byte  = c;
        bus.cmd_valid = 1'b1;
        tick(1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_byte  = '0;
        bus.cmd_valid = 1'b0;
        bus.rx_byte   = '0;
        bus.rx_strobe = 1'b0;
        tick(3);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owned", rx_owned, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        reset = 1'b0;
        tick(5);
        chk("idle_quiet", busy, 0);

        leds = 3'b100;
        wait_req("led1a");
        dev_xfer("led1_ed", ED, 1'b1, FA, 0);
        wait_req("led1b");
        dev_xfer("led1_04", 8'h04, 1'b1, FA, 0);
        wait_idle("led1");
        chk("led1_err", error, 0);
        tick(50);
        chk("led1_noresend", busy, 0);

        bus.cmd_byte  = FF;
        bus.cmd_valid = 1'b1;
        leds = 3'b010;
        tick(1);
        bus.cmd_valid = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_owned", rx_owned, 1);
        wait_req("prio_ff");
        dev_xfer("prio_ff", FF, 1'b1, FA, 0);
        wait_req("prio_ed");
        dev_xfer("prio_ed", ED, 1'b1, FA, 0);
        wait_req("prio_02");
        dev_xfer("prio_02", 8'h02, 1'b1, FA, 0);
        wait_idle("prio");
        chk("prio_err", error, 0);

        send_cmd(8'hF4);
        wait_req("fe1");
        dev_xfer("fe1", 8'hF4, 1'b1, FE, 0);
        wait_req("fe2");
        dev_xfer("fe2", 8'hF4, 1'b1, FA, 0);
        wait_idle("fe");
        chk("fe_err", error, 0);

        send_cmd(8'hF2);
        wait_req("nack1");
        dev_xfer("nack1", 8'hF2, 1'b0, FA, 0);
        wait_req("nack2");
        dev_xfer("nack2", 8'hF2, 1'b1, FA, 0);
        wait_idle("nack");
        chk("nack_err", error, 0);

        send_cmd(8'hEE);
        for (int a = 0; a < 3; a++) begin
            int w = 0;
            wait_req("tmo");
            while (data_oe && w < TMO + 100) begin
                tick(1);
                w++;
            end
            tick(1);
            chk("tmo_len", req_last, TMO);
        end
        wait_idle("tmo");
        chk("tmo_err", error, 1);
        chk("tmo_clk_oe", clk_oe, 0);
        chk("tmo_data_oe", data_oe, 0);

        send_cmd(8'hAA);
        wait_req("rst");
        dev_xfer("rst", 8'hAA, 1'b1, FA, 5);
        chk("rst_bit4", data_oe, 1);
        reset = 1'b1;
        tick(1);
        chk("rst_mid_clk", clk_oe, 0);
        chk("rst_mid_data", data_oe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", error, 0);
        leds = 3'b001;
        tick(2);
        reset = 1'b0;
        wait_req("rst_led");
        dev_xfer("rst_ed", ED, 1'b1, FA, 0);
        wait_req("rst_01");
        dev_xfer("rst_01", 8'h01, 1'b1, FA, 0);
        wait_idle("rst_led");
        chk("rst_led_err", error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
